// File: rtl/scan_bist_pkg.sv
// Shared types and constants for the logic-BIST controller slice.
// Optional build macro used by scan_bist_ctrl: SCAN_FIRST_UNLOAD_MASK_EN.
package scan_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    // x^16+x^14+x^13+x^11+1 in polynomial order (bit 15 = x^16 side)
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

    // A right-shifting Fibonacci register taps the mirror image of the polynomial mask.
    function automatic logic [15:0] tap_select(input logic [15:0] mask);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i] = mask[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_bist_ctrl_lfsr.sv
// 16-bit right-shifting Fibonacci LFSR with load, enable and serial XOR input.
// Serial input tied low gives a PRPG; driven by scan data it acts as a MISR.
module scan_lfsr
    import scan_bist_pkg::*;
#(
    parameter logic [15:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        serial_in,
    output logic [15:0] q
);

    localparam logic [15:0] TAPS = tap_select(LFSR_TAP_MASK);

    logic fb;

    assign fb = (^(q & TAPS)) ^ serial_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/scan_bist_ctrl.sv
// Logic-BIST controller: PRPG feeds the core scan chain, MISR compacts its output.
// Build macro SCAN_FIRST_UNLOAD_MASK_EN masks compaction during the first pattern's shift.
module scan_bist_ctrl
    import scan_bist_pkg::*;
#(
    parameter int unsigned CHAIN_LEN     = 64,
    parameter int unsigned PATTERN_COUNT = 256,
    parameter logic [15:0] SEED          = DEFAULT_SEED,
    parameter logic [15:0] GOLDEN        = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        scan_out,
    output logic        scan_in,
    output logic        scan_en,
    output logic        test_mode,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned PW = $clog2(PATTERN_COUNT + 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(PATTERN_COUNT - 1);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("scan_bist_ctrl: SEED must be non-zero");
    end

    state_t        state;
    logic [SW-1:0] shift_cnt;
    logic [PW-1:0] pat_cnt;
    logic [15:0]   prpg_q;
    logic          shifting;
    logic          run_load;
    logic          misr_en;

    assign shifting = (state == SHIFT) || (state == UNLOAD);
    assign run_load = (state == IDLE) && start && !abort;

`ifdef SCAN_FIRST_UNLOAD_MASK_EN
    assign misr_en = shifting && !abort && (pat_cnt != '0);
`else
    assign misr_en = shifting && !abort;
`endif

    scan_lfsr #(.RST_VAL(SEED)) u_prpg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (shifting && !abort),
        .load      (run_load),
        .load_val  (SEED),
        .serial_in (1'b0),
        .q         (prpg_q)
    );

    scan_lfsr #(.RST_VAL(16'h0000)) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (misr_en),
        .load      (run_load),
        .load_val  (16'h0000),
        .serial_in (scan_out),
        .q         (signature)
    );

    assign scan_in = prpg_q[0];

    // A non-zero seed keeps the PRPG out of its lock-up state.
    assert property (@(posedge clk) disable iff (!rst_n) prpg_q != 16'h0000);

    // Outputs are assigned alongside each transition so they reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            scan_en   <= 1'b0;
            test_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                shift_cnt <= '0;
                pat_cnt   <= '0;
                scan_en   <= 1'b0;
                test_mode <= 1'b0;
                busy      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= SHIFT;
                            shift_cnt <= '0;
                            pat_cnt   <= '0;
                            pass      <= 1'b0;
                            scan_en   <= 1'b1;
                            test_mode <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (shift_cnt == SHIFT_LAST) begin
                            state     <= CAPTURE;
                            shift_cnt <= '0;
                            scan_en   <= 1'b0;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        pat_cnt <= pat_cnt + 1'b1;
                        scan_en <= 1'b1;
                        state   <= (pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
                    end
                    UNLOAD: begin
                        if (shift_cnt == SHIFT_LAST) begin
                            state     <= DONE;
                            shift_cnt <= '0;
                            scan_en   <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        pass      <= (signature == GOLDEN);
                        test_mode <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        scan_en   <= 1'b0;
                        test_mode <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed, table-driven bench for scan_bist_ctrl (CHAIN_LEN=4, PATTERN_COUNT=2).
// Honours SCAN_FIRST_UNLOAD_MASK_EN in its reference MISR model.
module tb_scan_bist_ctrl;

    localparam int unsigned CL       = 4;
    localparam int unsigned PC       = 2;
    localparam logic [15:0] SEED_V   = 16'hACE1;
    localparam logic [15:0] GOLDEN_V = 16'h0000;
    localparam int          RUN_LEN  = 16;
`ifdef SCAN_FIRST_UNLOAD_MASK_EN
    localparam bit MASK_FIRST = 1'b1;
`else
    localparam bit MASK_FIRST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        scan_out;
    logic        scan_in;
    logic        scan_en;
    logic        test_mode;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    typedef struct {
        logic start;
        logic en;
        logic busy;
        logic done;
        logic tm;
    } vec_t;

    vec_t vec [1:RUN_LEN];
    int   checks = 0;
    int   errors = 0;

    scan_bist_ctrl #(
        .CHAIN_LEN     (CL),
        .PATTERN_COUNT (PC),
        .SEED          (SEED_V),
        .GOLDEN        (GOLDEN_V)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .scan_out  (scan_out),
        .scan_in   (scan_in),
        .scan_en   (scan_en),
        .test_mode (test_mode),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // x^16+x^14+x^13+x^11+1, shifting right, feedback s0^s2^s3^s5 into bit 15
    function automatic logic [15:0] lstep(input logic [15:0] s, input logic si);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5] ^ si;
        return {fb, s[15:1]};
    endfunction

    // mode 0: scan_out=0, 1: 4-cycle chain delay of scan_in, 2: scan_out=1
    task automatic run_bist(input int mode, input int flip_t, input int abort_t, output logic [15:0] sig);
        logic [15:0] rp;
        logic [15:0] rm;
        logic [3:0]  dly;
        logic        so;
        rp = SEED_V;
        rm = '0;
        dly = '0;
        sig = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= RUN_LEN; t++) begin
            check($sformatf("scan_en[%0d]", t), scan_en, vec[t].en);
            check($sformatf("busy[%0d]", t), busy, vec[t].busy);
            check($sformatf("done[%0d]", t), done, vec[t].done);
            check($sformatf("test_mode[%0d]", t), test_mode, vec[t].tm);
            check($sformatf("scan_in[%0d]", t), scan_in, rp[0]);
            check($sformatf("signature[%0d]", t), signature, rm);
            check($sformatf("pass[%0d]", t), pass, (t == RUN_LEN) ? (rm == GOLDEN_V) : 1'b0);
            start = vec[t].start;
            case (mode)
                0:       so = 1'b0;
                1:       so = dly[3];
                default: so = 1'b1;
            endcase
            if (t == flip_t) so = ~so;
            scan_out = so;
            dly = {dly[2:0], rp[0]};
            if (vec[t].en) begin
                if (!(MASK_FIRST && t <= int'(CL))) rm = lstep(rm, so);
                rp = lstep(rp, 1'b0);
            end
            if (t == abort_t) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_test_mode", test_mode, 1'b0);
                check("abort_scan_en", scan_en, 1'b0);
                check("abort_pass", pass, 1'b0);
                for (int k = 0; k < 10; k++) begin
                    check($sformatf("abort_no_done[%0d]", k), done, 1'b0);
                    @(negedge clk);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        sig = rm;
    endtask

    initial begin
        logic [RUN_LEN-1:0] en_p, busy_p, done_p, tm_p, start_p;
        logic [15:0] sig_a, sig_b, sig_c, sig_d, sig_x;

        en_p    = 16'b1111_0_1111_0_1111_00;
        busy_p  = 16'b1111_1_1111_1_1111_00;
        done_p  = 16'b0000_0_0000_0_0000_10;
        tm_p    = 16'b1111_1_1111_1_1111_10;
        start_p = 16'b0010_0_0000_0_0000_00;  // start while busy in cycle 3
        for (int t = 1; t <= RUN_LEN; t++) begin
            vec[t] = '{start: start_p[RUN_LEN-t], en: en_p[RUN_LEN-t], busy: busy_p[RUN_LEN-t],
                       done: done_p[RUN_LEN-t], tm: tm_p[RUN_LEN-t]};
        end

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        scan_out = 1'b0;
        #12;
        check("rst_scan_en", scan_en, 1'b0);
        check("rst_test_mode", test_mode, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_scan_in", scan_in, SEED_V[0]);
        check("rst_signature", signature, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_bist(0, 0, 0, sig_a);
        check("zero_run_signature", signature, 16'h0000);
        check("zero_run_pass", pass, 1'b1);

        run_bist(1, 0, 0, sig_b);
        run_bist(1, 0, 7, sig_x);
        run_bist(1, 0, 0, sig_x);
        check("rerun_after_abort_sig", signature, sig_b);

        run_bist(1, 7, 0, sig_c);
        check("flip_changes_sig", (signature != sig_b), 1'b1);
        check("flip_sig_model", signature, sig_c);

        run_bist(2, 0, 0, sig_d);
        check("ones_run_sig", signature, sig_d);

        // asynchronous reset in the middle of UNLOAD
        scan_out = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        check("pre_reset_scan_en", scan_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_scan_en", scan_en, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_test_mode", test_mode, 1'b0);
        check("async_rst_scan_in", scan_in, SEED_V[0]);
        @(negedge clk);
        rst_n = 1'b1;
        scan_out = 1'b0;
        @(negedge clk);
        check("post_rst_signature", signature, 16'h0000);
        check("post_rst_busy", busy, 1'b0);

        // abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_start_busy", busy, 1'b0);
        check("abort_start_test_mode", test_mode, 1'b0);
        check("abort_start_scan_en", scan_en, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_start_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
